multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the per-state control word into the shared datapath: PC, IR, register file, ALU and memory port. Handles variable-latency instruction and data memory with req/ack handshakes. Counts retired instructions and traps on an illegal opcode or a memory timeout.

---
 rtl/core_pkg.sv | 73 +++++++
 rtl/seq_opclass_decode.sv | 30 +++
 rtl/multicycle_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the sequencer state encoding, the RV32I major opcodes, the instruction
// class enum produced by the decoder, and the datapath mux/ALU encodings.
package core_pkg;

  // Sequencer states; values are visible on the debug state output.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // Instruction class captured in DECODE and held for the rest of the instruction.
  typedef enum logic [2:0] {
    ClsR      = 3'd0,
    ClsImm    = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4,
    ClsJal    = 3'd5,
    ClsLui    = 3'd6,
    ClsAuipc  = 3'd7
  } opclass_e;

  // ALU operation select.
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;
  localparam logic [1:0] AluPassB  = 2'b11;

  // Register write-back source select.
  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  // Next-PC select.
  localparam logic [1:0] PcPlus4  = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJal    = 2'b10;

  typedef struct packed {
    logic       alu_src;  // 0 = rs2, 1 = immediate
    logic [1:0] alu_op;
  } alu_ctrl_t;

  // ALU operand/operation per class, shared by EXEC and MEM (address stays stable in MEM).
  function automatic alu_ctrl_t alu_ctrl(opclass_e cls);
    alu_ctrl_t res;
    res = '{alu_src: 1'b1, alu_op: AluAdd};
    case (cls)
      ClsR:      res = '{alu_src: 1'b0, alu_op: AluFunct};
      ClsImm:    res = '{alu_src: 1'b1, alu_op: AluFunct};
      ClsBranch: res = '{alu_src: 1'b0, alu_op: AluBranch};
      ClsLui:    res = '{alu_src: 1'b1, alu_op: AluPassB};
      default:   res = '{alu_src: 1'b1, alu_op: AluAdd};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_opclass_decode.sv
// Combinational opcode classifier for the multi-cycle sequencer.
// Ports:
//   opcode  - instr[6:0] from the IR
//   opclass - decoded instruction class (don't care when illegal is set)
//   illegal - opcode is not one of the supported RV32I major opcodes
module seq_opclass_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   opclass,
  output logic       illegal
);

  always_comb begin
    opclass = ClsR;
    illegal = 1'b0;
    case (opcode)
      OpcR:      opclass = ClsR;
      OpcImm:    opclass = ClsImm;
      OpcLoad:   opclass = ClsLoad;
      OpcStore:  opclass = ClsStore;
      OpcBranch: opclass = ClsBranch;
      OpcJal:    opclass = ClsJal;
      OpcLui:    opclass = ClsLui;
      OpcAuipc:  opclass = ClsAuipc;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives the
// per-state control word into the shared datapath. Memory handshakes are req/ack
// with a bounded wait; an illegal opcode or a wait overrun parks the FSM in TRAP.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset (forces all outputs 0)
//   opcode                - instr[6:0] from IR, valid from DECODE
//   imem_ack, dmem_ack    - memory handshake acks, honoured only in FETCH / MEM
//   br_taken              - branch condition from the ALU, used in EXEC
//   imem_req, ir_we       - instruction fetch request, IR load
//   dmem_req, dmem_we     - data request, store enable
//   alu_src, alu_op       - ALU operand B select and operation
//   reg_we, wb_sel        - register write enable and source
//   pc_we, pc_sel         - PC update and next-PC source
//   trap                  - sticky fault flag
//   state                 - current state (debug)
//   retire_cnt            - retired instruction count, wraps silently
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  opclass_e         class_q, class_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  opclass_e dec_class;
  logic     dec_illegal;
  logic     timeout;

  seq_opclass_decode u_decode (
    .opcode  (opcode),
    .opclass (dec_class),
    .illegal (dec_illegal)
  );

  // Wait counter reached the limit; only meaningful when the ack is absent.
  assign timeout = (wait_q == TimeoutLimit);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      class_q <= ClsR;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. wait_d clears on every entry to FETCH or MEM.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    wait_d  = wait_q;
    case (state_q)
      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d = StTrap;
        end else begin
          class_d = dec_class;
          state_d = StExec;
        end
      end
      StExec: begin
        if (class_q == ClsBranch) begin
          state_d = StFetch;
          wait_d  = '0;
        end else if (class_q == ClsLoad || class_q == ClsStore) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          if (class_q == ClsStore) begin
            state_d = StFetch;
            wait_d  = '0;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        state_d = StFetch;
        wait_d  = '0;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // Output logic: control word from state and registered class.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_src  = 1'b0;
    alu_op   = AluAdd;
    reg_we   = 1'b0;
    wb_sel   = WbAlu;
    pc_we    = 1'b0;
    pc_sel   = PcPlus4;
    trap     = 1'b0;
    retire   = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      StExec: begin
        {alu_src, alu_op} = alu_ctrl(class_q);
        if (class_q == ClsBranch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PcBranch : PcPlus4;
          retire = 1'b1;
        end
      end
      StMem: begin
        {alu_src, alu_op} = alu_ctrl(class_q);
        dmem_req = 1'b1;
        dmem_we  = (class_q == ClsStore);
        // A store retires in its ack cycle; a load finishes in WB.
        if (class_q == ClsStore && dmem_ack) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      StWb: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (class_q == ClsLoad) begin
          wb_sel = WbMem;
        end else if (class_q == ClsJal) begin
          wb_sel = WbPc4;
        end
        if (class_q == ClsJal) begin
          pc_sel = PcJal;
        end
      end
      StTrap:  trap = 1'b1;
      default: ;
    endcase
    // Reset silences the datapath in the same cycle, dropping any pending request.
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      alu_src  = 1'b0;
      alu_op   = AluAdd;
      reg_we   = 1'b0;
      wb_sel   = WbAlu;
      pc_we    = 1'b0;
      pc_sel   = PcPlus4;
      trap     = 1'b0;
      retire   = 1'b0;
    end
  end

  assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  assign state      = rst_n ? state_q : 3'd0;
  assign retire_cnt = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT=4, CNT_W=4).
// A per-instruction cycle trace is generated from the instruction class and the
// chosen ack delays, then replayed cycle by cycle against the DUT.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          imem_ack, dmem_ack, br_taken;
  logic          imem_req, ir_we, dmem_req, dmem_we, alu_src, reg_we, pc_we, trap;
  logic [1:0]    alu_op, wb_sel, pc_sel;
  logic [2:0]    state;
  logic [CW-1:0] retire_cnt;
  logic [13:0]   obs;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  multicycle_sequencer #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .trap       (trap),
    .state      (state),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {imem_req, ir_we, dmem_req, dmem_we, alu_src, alu_op, reg_we, wb_sel,
                pc_we, pc_sel, trap};

  typedef struct {
    int          st;
    logic [13:0] ctrl;
    bit          iack;
    bit          dack;
    bit          br;
    bit          ret;
  } cyc_t;

  cyc_t tr[$];
  bit   trapped;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

  function automatic logic [13:0] cw(bit ireq, bit irw, bit dreq, bit dwe, logic [2:0] alu,
                                     bit rwe, logic [1:0] wb, bit pwe, logic [1:0] ps, bit tr_f);
    return {ireq, irw, dreq, dwe, alu, rwe, wb, pwe, ps, tr_f};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // 0 R, 1 IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC, -1 illegal
  function automatic int classify(logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b0110111: return 6;
      7'b0010111: return 7;
      default:    return -1;
    endcase
  endfunction

  // {alu_src, alu_op} expected in EXEC/MEM for a class.
  function automatic logic [2:0] alu_of(int cls);
    case (cls)
      0:       return 3'b010;
      1:       return 3'b110;
      4:       return 3'b001;
      6:       return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  function automatic cyc_t mk(int st, logic [13:0] c, bit ia, bit da, bit br, bit ret);
    cyc_t r;
    r.st = st; r.ctrl = c; r.iack = ia; r.dack = da; r.br = br; r.ret = ret;
    return r;
  endfunction

  // Expected cycle trace: iw/dw = cycles without ack before the ack arrives.
  task automatic build(input logic [6:0] op, input int iw, input int dw, input bit br,
                       input int ntrap, input bit abort_mem);
    int         cls;
    logic [2:0] alu;
    bit         done;
    bit         st;
    logic [1:0] wb, ps;
    cls = classify(op);
    alu = alu_of(cls);
    tr.delete();
    trapped = 0;
    done    = 0;
    for (int i = 0; i < iw && !trapped; i++) begin
      tr.push_back(mk(0, cw(1, 0, 0, 0, 3'b0, 0, 2'b0, 0, 2'b0, 0), 0, rb(), rb(), 0));
      if (i == int'(TO)) trapped = 1;
    end
    if (!trapped) begin
      tr.push_back(mk(0, cw(1, 1, 0, 0, 3'b0, 0, 2'b0, 0, 2'b0, 0), 1, rb(), rb(), 0));
      tr.push_back(mk(1, 14'b0, rb(), rb(), rb(), 0));
      if (cls < 0) trapped = 1;
    end
    if (!trapped) begin
      if (cls == 4) begin
        ps = br ? 2'b01 : 2'b00;
        tr.push_back(mk(2, cw(0, 0, 0, 0, alu, 0, 2'b0, 1, ps, 0), rb(), rb(), br, 1));
        done = 1;
      end else begin
        tr.push_back(mk(2, cw(0, 0, 0, 0, alu, 0, 2'b0, 0, 2'b0, 0), rb(), rb(), rb(), 0));
      end
    end
    if (!trapped && !done && (cls == 2 || cls == 3)) begin
      st = (cls == 3);
      for (int i = 0; i < dw && !trapped && !done; i++) begin
        tr.push_back(mk(3, cw(0, 0, 1, st, alu, 0, 2'b0, 0, 2'b0, 0), rb(), 0, rb(), 0));
        if (i == int'(TO)) trapped = 1;
        if (abort_mem) done = 1;
      end
      if (!trapped && !done) begin
        tr.push_back(mk(3, cw(0, 0, 1, st, alu, 0, 2'b0, st, 2'b0, 0), rb(), 1, rb(), st));
        if (st) done = 1;
      end
    end
    if (!trapped && !done) begin
      wb = (cls == 2) ? 2'b01 : (cls == 5) ? 2'b10 : 2'b00;
      ps = (cls == 5) ? 2'b10 : 2'b00;
      tr.push_back(mk(4, cw(0, 0, 0, 0, 3'b0, 1, wb, 1, ps, 0), rb(), rb(), rb(), 1));
    end
    if (trapped) begin
      for (int i = 0; i < ntrap; i++) begin
        tr.push_back(mk(5, cw(0, 0, 0, 0, 3'b0, 0, 2'b0, 0, 2'b0, 1), rb(), rb(), rb(), 0));
      end
    end
  endtask

  // Entered inside a cycle before its rising edge; leaves at the next falling edge.
  task automatic run_trace(input string name);
    foreach (tr[k]) begin
      imem_ack = tr[k].iack;
      dmem_ack = tr[k].dack;
      br_taken = tr[k].br;
      #1;
      checks++;
      if (state !== 3'(tr[k].st)) begin
        errors++;
        $display("FAIL %s cyc %0d state got %0d exp %0d", name, k, state, tr[k].st);
      end
      checks++;
      if (obs !== tr[k].ctrl) begin
        errors++;
        $display("FAIL %s cyc %0d ctrl got %b exp %b", name, k, obs, tr[k].ctrl);
      end
      checks++;
      if (retire_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL %s cyc %0d retire_cnt got %0d exp %0d", name, k, retire_cnt, exp_cnt);
      end
      if (tr[k].ret) exp_cnt = (exp_cnt + 1) % (1 << CW);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input int iw, input int dw,
                           input bit br, input int ntrap, input bit abort_mem);
    opcode = op;
    build(op, iw, dw, br, ntrap, abort_mem);
    run_trace(name);
  endtask

  task automatic test_reset(input string name);
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    br_taken = 1'b1;
    #1;
    checks++;
    if (obs !== 14'b0) begin
      errors++;
      $display("FAIL %s in_reset ctrl got %b exp 0", name, obs);
    end
    checks++;
    if (state !== 3'd0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL %s in_reset state/cnt got %0d/%0d exp 0/0", name, state, retire_cnt);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    br_taken = 1'b0;
    #1;
    checks++;
    if (obs !== cw(1, 0, 0, 0, 3'b0, 0, 2'b0, 0, 2'b0, 0)) begin
      errors++;
      $display("FAIL %s after_reset ctrl got %b exp imem_req only", name, obs);
    end
    checks++;
    if (state !== 3'd0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL %s after_reset state/cnt got %0d/%0d exp 0/0", name, state, retire_cnt);
    end
    exp_cnt = 0;
  endtask

  task automatic test_r_type();
    run_instr("r_type", 7'b0110011, 0, 0, 0, 0, 0);
    run_instr("imm", 7'b0010011, 1, 0, 0, 0, 0);
    run_instr("lui", 7'b0110111, 0, 0, 1, 0, 0);
    run_instr("auipc", 7'b0010111, 0, 0, 0, 0, 0);
    run_instr("jal", 7'b1101111, 2, 0, 0, 0, 0);
  endtask

  task automatic test_load_wait();
    run_instr("load_wait3", 7'b0000011, 0, 3, 0, 0, 0);
    run_instr("store_wait2", 7'b0100011, 0, 2, 0, 0, 0);
    run_instr("store_fast", 7'b0100011, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("branch_taken", 7'b1100011, 0, 0, 1, 0, 0);
    run_instr("branch_not_taken", 7'b1100011, 0, 0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 7'b1111111, 0, 0, 0, 100, 0);
    test_reset("illegal_reset");
  endtask

  task automatic test_fetch_timeout();
    run_instr("fetch_timeout", 7'b0110011, 5, 0, 0, 5, 0);
    test_reset("fetch_timeout_reset");
    run_instr("fetch_ack_at_limit", 7'b0110011, 4, 0, 0, 0, 0);
  endtask

  task automatic test_mem_timeout();
    run_instr("mem_ack_at_limit", 7'b0000011, 0, 4, 0, 0, 0);
    run_instr("mem_timeout", 7'b0000011, 0, 5, 0, 5, 0);
    test_reset("mem_timeout_reset");
  endtask

  task automatic test_retire_wrap();
    test_reset("wrap_reset");
    for (int i = 0; i < 16; i++) begin
      run_instr("wrap", legal_ops[$urandom_range(0, 7)], $urandom_range(0, 2),
                $urandom_range(0, 2), rb(), 0, 0);
    end
    checks++;
    if (retire_cnt !== '0) begin
      errors++;
      $display("FAIL retire_wrap got %0d exp 0", retire_cnt);
    end
  endtask

  task automatic test_reset_in_mem();
    run_instr("pre_mem_reset", 7'b0110011, 0, 0, 0, 0, 0);
    run_instr("mem_abort", 7'b0100011, 0, 3, 0, 0, 1);
    test_reset("reset_in_mem");
  endtask

  task automatic test_random();
    logic [6:0] op;
    int         iw, dw;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'b0000000 : legal_ops[$urandom_range(0, 7)];
      iw = ($urandom_range(0, 11) == 0) ? 5 : $urandom_range(0, 3);
      dw = ($urandom_range(0, 11) == 0) ? 5 : $urandom_range(0, 3);
      run_instr("random", op, iw, dw, rb(), 3, 0);
      if (trapped) test_reset("random_reset");
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    test_reset("reset");
    test_r_type();
    test_load_wait();
    test_branch();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_retire_wrap();
    test_reset_in_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
